// File: rtl/tag_pkg.sv
// Shared constants, enums and the byte-rotate helper for the tag engine.
package tag_pkg;

    localparam int DATA_SIZE   = 32;
    localparam int TAG_SIZE    = 8;
    localparam int NUM_BLOCKS  = DATA_SIZE / TAG_SIZE;
    localparam int KEY_W       = 16;
    localparam int KEY_FIELD_W = KEY_W / NUM_BLOCKS;
    localparam int ROT_W       = 3;

    typedef enum logic [1:0] {IDLE, COMPUTE, RESPOND} state_e;
    typedef enum logic {OP_GEN, OP_CHK} op_e;

    // Rotate left by shifting a doubled copy; amount 0 returns v unchanged.
    function automatic logic [TAG_SIZE-1:0] rotl(input logic [TAG_SIZE-1:0] v,
                                                 input logic [ROT_W-1:0]    n);
        logic [2*TAG_SIZE-1:0] w;
        w = {v, v} << n;
        return w[2*TAG_SIZE-1:TAG_SIZE];
    endfunction

endpackage

// File: rtl/tag_core.sv
// Combinational tag function: per-byte conditional invert, keyed rotate, XOR fold.
module tag_core
    import tag_pkg::*;
(
    input  logic [DATA_SIZE-1:0] data,
    input  logic [KEY_W-1:0]     key,
    output logic [TAG_SIZE-1:0]  tag
);

    always_comb begin
        // NOTE: default assignment first so no path through the block can infer a latch.
        tag = '0;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            tag = tag ^ rotl(key[i] ? ~data[TAG_SIZE*i +: TAG_SIZE] : data[TAG_SIZE*i +: TAG_SIZE],
                             key[KEY_FIELD_W*i +: ROT_W]);
        end
    end

endmodule

// File: rtl/tag_engine_arbiter.sv
// Round-robin sharing of one tag_core between the store-side gen and load-side chk ports.
module tag_engine_arbiter
    import tag_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [KEY_W-1:0]     cfg_key,
    output logic                 cfg_ready,
    input  logic                 gen_req_valid,
    output logic                 gen_req_ready,
    input  logic [DATA_SIZE-1:0] gen_req_data,
    output logic                 gen_rsp_valid,
    input  logic                 gen_rsp_ready,
    output logic [TAG_SIZE-1:0]  gen_rsp_tag,
    input  logic                 chk_req_valid,
    output logic                 chk_req_ready,
    input  logic [DATA_SIZE-1:0] chk_req_data,
    input  logic [TAG_SIZE-1:0]  chk_req_tag,
    output logic                 chk_rsp_valid,
    input  logic                 chk_rsp_ready,
    output logic                 chk_rsp_match,
    output logic [CNT_W-1:0]     mismatch_cnt,
    input  logic                 mismatch_clr
);

    state_e                state_q;
    op_e                   op_q;
    op_e                   rr_q;
    logic [DATA_SIZE-1:0]  data_q;
    logic [TAG_SIZE-1:0]   stag_q;
    logic [KEY_W-1:0]      key_q;
    logic [TAG_SIZE-1:0]   core_tag;

    logic                  any_req;
    logic                  idle_live;
    op_e                   grant_op;
    logic                  rsp_hs;
    logic                  mismatch_inc;

    tag_core u_core (
        .data (data_q),
        .key  (key_q),
        .tag  (core_tag)
    );

    assign any_req   = gen_req_valid | chk_req_valid;
    assign idle_live = (state_q == IDLE) && !reset;
    assign grant_op  = (chk_req_valid && (!gen_req_valid || rr_q == OP_CHK)) ? OP_CHK : OP_GEN;

    // Ready is the grant itself, so it is combinational and held low while in reset.
    assign gen_req_ready = idle_live && gen_req_valid && (grant_op == OP_GEN);
    assign chk_req_ready = idle_live && chk_req_valid && (grant_op == OP_CHK);
    assign cfg_ready     = idle_live && !any_req;

    assign rsp_hs       = (op_q == OP_GEN) ? gen_rsp_ready : chk_rsp_ready;
    assign mismatch_inc = (state_q == COMPUTE) && (op_q == OP_CHK) && (core_tag != stag_q)
                          && (mismatch_cnt != '1);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
        if (reset) begin
            state_q       <= IDLE;
            op_q          <= OP_GEN;
            rr_q          <= OP_GEN;
            data_q        <= '0;
            stag_q        <= '0;
            key_q         <= '0;
            gen_rsp_valid <= 1'b0;
            gen_rsp_tag   <= '0;
            chk_rsp_valid <= 1'b0;
            chk_rsp_match <= 1'b0;
            mismatch_cnt  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        op_q    <= grant_op;
                        data_q  <= (grant_op == OP_CHK) ? chk_req_data : gen_req_data;
                        stag_q  <= chk_req_tag;
                        rr_q    <= (grant_op == OP_CHK) ? OP_GEN : OP_CHK;
                        state_q <= COMPUTE;
                    end else if (cfg_we) begin
                        key_q <= cfg_key;
                    end
                end
                COMPUTE: begin
                    if (op_q == OP_GEN) begin
                        gen_rsp_tag   <= core_tag;
                        gen_rsp_valid <= 1'b1;
                    end else begin
                        chk_rsp_match <= (core_tag == stag_q);
                        chk_rsp_valid <= 1'b1;
                    end
                    state_q <= RESPOND;
                end
                RESPOND: begin
                    if (rsp_hs) begin
                        gen_rsp_valid <= 1'b0;
                        chk_rsp_valid <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Clear wins over a same-cycle increment.
            if (mismatch_clr) begin
                mismatch_cnt <= '0;
            end else if (mismatch_inc) begin
                mismatch_cnt <= mismatch_cnt + CNT_W'(1);
            end
        end
    end

endmodule
